// File: rtl/rr_merge_4to1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_merge_4to1_pkg : shared constants and FSM encoding for the merge   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package rr_merge_4to1_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage : rr_merge_4to1_pkg
`default_nettype wire

// File: rtl/rr_merge_4to1_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick4 : combinational round-robin picker, search starts after      |
// | i_last_grant and wraps back to it. Rev 1.0                            |
// +----------------------------------------------------------------------+
module rr_pick4
  import rr_merge_4to1_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_last_grant,
  output logic [SEL_W-1:0]  o_winner,
  output logic              o_any
);

  logic [SEL_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = i_last_grant + SEL_W'(k);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
    o_any = |i_req;
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_merge_4to1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_merge_4to1 : packet-locked round-robin 4:1 stream merge with a     |
// | one-entry registered output and source tagging. Rev 1.0              |
// +----------------------------------------------------------------------+
module rr_merge_4to1
  import rr_merge_4to1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_grant;
  logic [SEL_W-1:0] r_last_grant;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SEL_W-1:0] r_out_sel;

  logic [WIDTH-1:0] w_ch_data [NUM_CH];
  logic [SEL_W-1:0] w_win;
  logic             w_any;
  logic             w_slot_free;
  logic             w_load;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    assign w_ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  rr_pick4 u_pick (
    .i_req        (in_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_win),
    .o_any        (w_any)
  );

  // The output slot can take a beat if empty or draining this same edge.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_load      = (r_state == BUSY) && in_valid[r_grant] && w_slot_free;

  always_comb begin
    in_ready = '0;
    if (!rst && (r_state == BUSY) && w_slot_free) begin
      in_ready[r_grant] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = BUSY;
      BUSY: if (w_load && in_last[r_grant]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= SEL_W'(NUM_CH - 1);
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_sel    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_any) begin
        r_grant <= w_win;
      end
      if (w_load && in_last[r_grant]) begin
        r_last_grant <= r_grant;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ch_data[r_grant];
        r_out_last  <= in_last[r_grant];
        r_out_sel   <= r_grant;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule : rr_merge_4to1
`default_nettype wire

// File: tb/tb_rr_merge_4to1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_merge_4to1 : directed + random stimulus against a packet-level  |
// | behavioural model of the merge. Rev 1.0                               |
// +----------------------------------------------------------------------+
module tb_rr_merge_4to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  always #5 clk = ~clk;

  rr_merge_4to1 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  typedef struct { logic [7:0] d; logic l; int gap; } beat_t;
  typedef struct { logic [7:0] d; logic l; logic [1:0] s; } obs_t;

  beat_t q[4][$];
  bit    hold[4];
  int    pct[4];
  int    acc_cnt[4];
  obs_t  log_q[$];
  int    n_chk = 0, n_err = 0;
  bit    in_pkt;
  logic [1:0] pkt_sel;

  // Model: owner = channel holding the packet lock, -1 while arbitrating.
  int         m_owner, m_ptr;
  logic       m_valid, m_last;
  logic [7:0] m_data;
  logic [1:0] m_sel;
  bit         m_acc[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ready();
    if (rst || m_owner < 0 || (m_valid && !out_ready)) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 4; c++) m_acc[c] = 0;
    if (rst) begin
      m_owner = -1; m_ptr = 3;
      m_valid = 0; m_data = 0; m_last = 0; m_sel = 0;
    end else if (m_owner >= 0) begin
      if (in_valid[m_owner] && (!m_valid || out_ready)) begin
        m_valid = 1;
        m_data  = in_data[m_owner*8 +: 8];
        m_last  = in_last[m_owner];
        m_sel   = 2'(m_owner);
        m_acc[m_owner] = 1;
        if (m_last) begin
          m_ptr = m_owner; m_owner = -1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end else begin
      if (m_valid && out_ready) m_valid = 0;
      for (int k = 1; k <= 4 && m_owner < 0; k++)
        if (in_valid[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int c = 0; c < 4; c++) begin
      if (!hold[c] && q[c].size() > 0) begin
        b = q[c][0];
        if (b.gap > 0) begin
          b.gap--; q[c][0] = b;
        end else if ($urandom_range(99) < pct[c]) begin
          hold[c] = 1;
        end
      end
      in_valid[c] = hold[c];
      if (q[c].size() > 0) begin
        in_data[c*8 +: 8] = q[c][0].d;
        in_last[c]        = q[c][0].l;
      end
    end
  endtask

  task automatic cycle(input logic ordy);
    obs_t o;
    drive();
    out_ready = ordy;
    #1;
    chk("in_ready", {28'd0, in_ready}, {28'd0, exp_ready()});
    if (!rst && out_valid && out_ready) begin
      o.d = out_data; o.l = out_last; o.s = out_sel;
      log_q.push_back(o);
      if (in_pkt) chk("no_interleave", {30'd0, out_sel}, {30'd0, pkt_sel});
      in_pkt  = !out_last;
      pkt_sel = out_sel;
    end
    @(posedge clk);
    model_edge();
    if (rst) in_pkt = 0;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_data",  {24'd0, out_data},  {24'd0, m_data});
    chk("out_last",  {31'd0, out_last},  {31'd0, m_last});
    chk("out_sel",   {30'd0, out_sel},   {30'd0, m_sel});
    for (int c = 0; c < 4; c++) begin
      if (m_acc[c]) begin
        void'(q[c].pop_front());
        hold[c] = 0;
        acc_cnt[c]++;
      end
    end
  endtask

  task automatic flush();
    for (int c = 0; c < 4; c++) begin
      q[c].delete(); hold[c] = 0; acc_cnt[c] = 0; pct[c] = 100;
    end
    log_q.delete();
  endtask

  task automatic reset_dut();
    flush();
    rst = 1; cycle(1); rst = 0;
  endtask

  task automatic push(input int c, input logic [7:0] d, input logic l, input int gap);
    beat_t b;
    b.d = d; b.l = l; b.gap = gap;
    q[c].push_back(b);
  endtask

  int total;
  int left;

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    m_owner = -1; m_ptr = 3; m_valid = 0; m_data = 0; m_last = 0; m_sel = 0;
    in_pkt = 0; pkt_sel = 0;
    flush();

    // Reset then idle
    cycle(0); cycle(0);
    rst = 0;
    cycle(1); cycle(1);
    chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);

    // Single-channel 3-beat packet on ch2
    reset_dut();
    push(2, 8'hA1, 0, 0); push(2, 8'hA2, 0, 0); push(2, 8'hA3, 1, 0);
    repeat (8) cycle(1);
    chk("t2_count", log_q.size(), 3);
    if (log_q.size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk("t2_data", {24'd0, log_q[i].d}, 32'hA1 + i);
        chk("t2_sel",  {30'd0, log_q[i].s}, 32'd2);
        chk("t2_last", {31'd0, log_q[i].l}, (i == 2) ? 32'd1 : 32'd0);
      end

    // Round-robin fairness with single-beat packets
    reset_dut();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) push(c, 8'(8'h10 + c), 1, 0);
    repeat (30) cycle(1);
    chk("t3_count", log_q.size(), 12);
    for (int i = 0; i < log_q.size(); i++) begin
      chk("t3_sel",  {30'd0, log_q[i].s}, i % 4);
      chk("t3_data", {24'd0, log_q[i].d}, 32'h10 + (i % 4));
    end

    // Backpressure on ch1
    reset_dut();
    push(1, 8'h55, 0, 0); push(1, 8'h66, 1, 0);
    cycle(1); cycle(1);
    repeat (3) begin
      cycle(0);
      chk("t4_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h55});
    end
    repeat (6) cycle(1);
    chk("t4_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t4_b0", {22'd0, log_q[0].s, log_q[0].d}, {22'd0, 2'd1, 8'h55});
      chk("t4_b1", {22'd0, log_q[1].s, log_q[1].d}, {22'd0, 2'd1, 8'h66});
    end

    // Packet locking: ch0 gap mid-packet, ch3 waiting throughout
    reset_dut();
    push(0, 8'h01, 0, 0); push(0, 8'h02, 0, 0); push(0, 8'h03, 0, 2); push(0, 8'h04, 1, 0);
    push(3, 8'h33, 1, 0);
    repeat (16) cycle(1);
    chk("t5_count", log_q.size(), 5);
    if (log_q.size() == 5)
      for (int i = 0; i < 5; i++)
        chk("t5_order", {22'd0, log_q[i].s, log_q[i].d},
            (i < 4) ? {22'd0, 2'd0, 8'(i + 1)} : {22'd0, 2'd3, 8'h33});

    // Reset mid-packet on ch1
    reset_dut();
    for (int i = 0; i < 4; i++) push(1, 8'(8'h81 + i), (i == 3), 0);
    for (int i = 0; i < 20 && acc_cnt[1] < 2; i++) cycle(1);
    chk("t6_wait", acc_cnt[1], 2);
    rst = 1; cycle(1); rst = 0;
    chk("t6_flushed", {31'd0, out_valid}, 32'd0);
    flush();
    push(1, 8'h91, 1, 0); push(0, 8'h90, 1, 0);
    repeat (8) cycle(1);
    chk("t6_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t6_first", {30'd0, log_q[0].s}, 32'd0);
      chk("t6_second", {30'd0, log_q[1].s}, 32'd1);
    end

    // Randomized traffic
    reset_dut();
    total = 0;
    for (int c = 0; c < 4; c++) begin
      pct[c] = $urandom_range(100, 30);
      for (int p = 0; p < 12; p++) begin
        int len;
        len = $urandom_range(4, 1);
        for (int b = 0; b < len; b++) begin
          push(c, 8'($urandom), (b == len - 1), $urandom_range(2, 0));
          total++;
        end
      end
    end
    repeat (900) cycle($urandom_range(99) < 60);
    repeat (300) cycle(1);
    left = 0;
    for (int c = 0; c < 4; c++) left += q[c].size();
    chk("rand_drained", left, 0);
    chk("rand_count", log_q.size(), total);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_rr_merge_4to1
`default_nettype wire
